alu_pipe: RTL

- Parametrised, handshaked successor to the fixed 32-bit combinational ALU datapath.
- Accepts one operation per transaction over a valid/ready input channel and returns the result and flags over a valid/ready output channel.
- Single-cycle ops complete with 1-cycle latency; MUL is an iterative shift-add taking DATA_WIDTH cycles.
- Sits between the operand-issue logic and the result writeback; the existing ALU bench environment is the target verification harness.

---
 rtl/alu_pipe.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe
// ----------------------------------------------------------------------------
// Handshaked, parametrised ALU. One operation is accepted per transaction on
// a valid/ready input channel. The result and its flags are returned on a
// valid/ready output channel. Single-cycle ops have 1-cycle latency. The
// optional multiplier is an iterative shift-add that takes DATA_WIDTH cycles.
//
// Configuration macro:
//   ALU_MUL_EN  defined   : op 111 runs the iterative unsigned multiply and
//                           err is always 0.
//               undefined : no multiplier hardware. Op 111 completes in one
//                           cycle with result=0, z_flag=1 and err=1.
//
// Ports:
//   clock      in   system clock; all state changes on the rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   an operation is offered
//   in_ready   out  block can accept an operation (high only in IDLE)
//   src_a      in   operand A [DATA_WIDTH]
//   src_b      in   operand B [DATA_WIDTH]
//   op_code    in   operation select [3]
//                   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                   101 SLT, 110 SLL, 111 MUL
//   out_valid  out  result and flags are valid (high only in HOLD)
//   out_ready  in   consumer accepts the result
//   result     out  operation result [DATA_WIDTH]
//   z_flag     out  result == 0
//   c_flag     out  carry (ADD), borrow (SUB), upper-half non-zero (MUL)
//   v_flag     out  signed overflow (ADD/SUB)
//   n_flag     out  result MSB
//   err        out  illegal op (op 111 when the multiplier is not built)
// ============================================================================
module alu_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [2:0]            op_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  z_flag,
    output logic                  c_flag,
    output logic                  v_flag,
    output logic                  n_flag,
    output logic                  err
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef ALU_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'd1;
`endif

    logic [1:0] state;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs. Its outputs
    // are only captured on the accept edge.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH:0]   diff_ext;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_c;
    logic                  alu_v;
    logic                  alu_err;
    logic                  alu_z;
    logic                  alu_n;
    logic                  slt_bit;

    // The extra top bit of these sums carries out the carry and the borrow.
    assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
    assign diff_ext = {1'b0, src_a} - {1'b0, src_b};
    assign slt_bit  = ($signed(src_a) < $signed(src_b));

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_code)
            OP_ADD: begin
                alu_res = sum_ext[DATA_WIDTH-1:0];
                alu_c   = sum_ext[DATA_WIDTH];
                // Overflow when both operands share a sign that the sum does not.
                alu_v   = (src_a[DATA_WIDTH-1] == src_b[DATA_WIDTH-1]) &&
                          (sum_ext[DATA_WIDTH-1] != src_a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[DATA_WIDTH-1:0];
                alu_c   = diff_ext[DATA_WIDTH];
                // Overflow when operand signs differ and the result sign differs from A.
                alu_v   = (src_a[DATA_WIDTH-1] != src_b[DATA_WIDTH-1]) &&
                          (diff_ext[DATA_WIDTH-1] != src_a[DATA_WIDTH-1]);
            end
            OP_AND: alu_res = src_a & src_b;
            OP_OR:  alu_res = src_a | src_b;
            OP_XOR: alu_res = src_a ^ src_b;
            OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
            OP_SLL: alu_res = src_a << src_b[SHAMT_W-1:0];
            OP_MUL: begin
                // With the multiplier built, this path is never captured for op 111.
                alu_res = '0;
`ifndef ALU_MUL_EN
                alu_err = 1'b1;
`endif
            end
            default: alu_res = '0;
        endcase
    end

    assign alu_z = (alu_res == '0);
    assign alu_n = alu_res[DATA_WIDTH-1];

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------------
    // Iterative shift-add multiplier. The multiplicand moves left and the
    // multiplier moves right, one bit per cycle. The accumulator is double
    // width so that the upper half can drive the overflow carry.
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] mul_acc;
    logic [2*DATA_WIDTH-1:0] mul_mcand;
    logic [DATA_WIDTH-1:0]   mul_mplier;
    logic [SHAMT_W-1:0]      mul_cnt;
    logic [2*DATA_WIDTH-1:0] mul_next;
    logic                    mul_last;

    assign mul_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_last = (mul_cnt == SHAMT_W'(DATA_WIDTH - 1));
`endif

    // ------------------------------------------------------------------
    // Control FSM and output registers. Result and flags change only on
    // accept or on the final multiply step, so they are stable in HOLD.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            result <= '0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            v_flag <= 1'b0;
            n_flag <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_MUL_EN
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MUL_EN
                        if (op_code == OP_MUL) begin
                            state      <= ST_MUL;
                            mul_acc    <= '0;
                            mul_mcand  <= {{DATA_WIDTH{1'b0}}, src_a};
                            mul_mplier <= src_b;
                            mul_cnt    <= '0;
                        end else begin
                            state  <= ST_HOLD;
                            result <= alu_res;
                            z_flag <= alu_z;
                            c_flag <= alu_c;
                            v_flag <= alu_v;
                            n_flag <= alu_n;
                            err    <= alu_err;
                        end
`else
                        state  <= ST_HOLD;
                        result <= alu_res;
                        z_flag <= alu_z;
                        c_flag <= alu_c;
                        v_flag <= alu_v;
                        n_flag <= alu_n;
                        err    <= alu_err;
`endif
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    mul_acc    <= mul_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + SHAMT_W'(1);
                    // The last step's partial sum is the full product.
                    if (mul_last) begin
                        state  <= ST_HOLD;
                        result <= mul_next[DATA_WIDTH-1:0];
                        z_flag <= (mul_next[DATA_WIDTH-1:0] == '0);
                        c_flag <= |mul_next[2*DATA_WIDTH-1:DATA_WIDTH];
                        v_flag <= 1'b0;
                        n_flag <= mul_next[DATA_WIDTH-1];
                        err    <= 1'b0;
                    end
                end
`endif
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);

endmodule
